// File: rtl/bonsai_pkg.sv
// Shared lane geometry, terminator key and feeder state encoding for the
// bonsai merger input path.
package bonsai_pkg;
  localparam int LANES = 16;
  // The all-zero key is reserved as the end-of-run terminator.
  localparam logic TERM_KEY = 1'b0;

  typedef enum logic {FILL = 1'b0, TERM = 1'b1} feeder_state_t;

  function automatic int lane_slice(input int k, input int width);
    return k * width;
  endfunction
endpackage

// File: rtl/feeder_fifo.sv
// Show-ahead synchronous FIFO: head visible the cycle after the first write.
// Writes are dropped when full; reads are ignored when empty.
module feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_push  = i_wr & ~o_full;
  assign w_pop   = i_rd & ~o_empty;
  // Head reads as zero while empty so the bus never shows stale words.
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/run_feeder_16.sv
// Packs sorted tuples 16 per word, zero-terminates every run, buffers words in a
// show-ahead FIFO; word visible one cycle after commit; ready drops when full or in TERM.
module run_feeder_16
  import bonsai_pkg::*;
#(
  parameter int DATA_WIDTH = 80,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_WIDTH-1:0]       i_tuple,
  input  logic                        i_tuple_valid,
  input  logic                        i_last,
  output logic                        o_tuple_ready,
  output logic [LANES*DATA_WIDTH-1:0] o_fifo_data,
  output logic                        o_fifo_empty,
  input  logic                        i_fifo_read,
  output logic [CNT_W-1:0]            o_run_count,
  output logic                        o_underrun,
  output logic                        o_zero_err
);
  localparam int WW = LANES * DATA_WIDTH;
  localparam int LW = $clog2(LANES);

  feeder_state_t    r_state;
  logic [LW-1:0]    r_lane_idx;
  logic [WW-1:0]    r_pack;
  logic [CNT_W-1:0] r_run_count;
  logic             r_underrun;
  logic             r_zero_err;

  logic [WW-1:0]    w_word;
  logic [WW-1:0]    w_wdata;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_commit;
  logic             w_wr;
  logic             w_lane_last;

  assign w_lane_last   = (r_lane_idx == LW'(LANES-1));
  assign o_tuple_ready = (r_state == FILL) & ~w_full;
  assign w_accept      = i_tuple_valid & o_tuple_ready;
  assign w_commit      = w_accept & (i_last | w_lane_last);
  assign w_wr          = w_commit | ((r_state == TERM) & ~w_full);
  assign w_wdata       = (r_state == TERM) ? '0 : w_word;

  // Lanes above the incoming one are forced to zero: that is the in-word terminator.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LW'(k) < r_lane_idx)
        w_word[lane_slice(k, DATA_WIDTH) +: DATA_WIDTH] = r_pack[lane_slice(k, DATA_WIDTH) +: DATA_WIDTH];
      else if (LW'(k) == r_lane_idx)
        w_word[lane_slice(k, DATA_WIDTH) +: DATA_WIDTH] = i_tuple;
    end
  end

  feeder_fifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (i_fifo_read),
    .o_head  (o_fifo_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= FILL;
      r_lane_idx  <= '0;
      r_pack      <= '0;
      r_run_count <= '0;
      r_underrun  <= 1'b0;
      r_zero_err  <= 1'b0;
    end else begin
      if (i_fifo_read & w_empty) r_underrun <= 1'b1;
      if (w_accept & (i_tuple == {DATA_WIDTH{TERM_KEY}})) r_zero_err <= 1'b1;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_commit) begin
              r_pack     <= '0;
              r_lane_idx <= '0;
            end else begin
              r_pack     <= w_word;
              r_lane_idx <= r_lane_idx + LW'(1);
            end
            // A run filling exactly to lane 15 still owes a whole zero word.
            if (i_last) begin
              if (w_lane_last) r_state <= TERM;
              else             r_run_count <= r_run_count + CNT_W'(1);
            end
          end
        end
        TERM: begin
          if (~w_full) begin
            r_run_count <= r_run_count + CNT_W'(1);
            r_state     <= FILL;
          end
        end
      endcase
    end
  end

  assign o_fifo_empty = w_empty;
  assign o_run_count  = r_run_count;
  assign o_underrun   = r_underrun;
  assign o_zero_err   = r_zero_err;
endmodule
